prg_dma_loader: RTL and testbench

- Converts the PRG download byte stream from the ioctl interface into paced single-byte DMA writes for the PET hardware RAM port (dma_addr/dma_din/dma_we).
- After the download ends, it patches BASIC's end-of-program pointers so RUN/LIST work immediately.
- Sits between the data_io download stream and pet2001hw.
- Throttles the source through ioctl_wait, with a 2-entry buffer.

---
 rtl/prg_dma_loader.sv | 187 ++++++++++++++++++
 tb/tb_prg_dma_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_dma_loader.sv
// PRG download loader: turns the ioctl byte stream into paced DMA RAM writes and
// patches BASIC's end-of-program pointers once the file has been stored.
module prg_dma_loader #(
    parameter logic [15:0] RAM_TOP     = 16'h8000,
    parameter logic [15:0] FIXUP_BASE  = 16'h002A,
    parameter int          FIXUP_PAIRS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_slot,
    input  logic        prg_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] load_start,
    output logic [15:0] load_end
);

    typedef enum logic [2:0] {IDLE, HDR, DATA, DRAIN, FIXUP, FIN} state_t;

    localparam int FIX_WRITES = 2 * FIXUP_PAIRS;
    localparam int FIX_W      = $clog2(FIX_WRITES + 1);
    localparam logic [FIX_W-1:0] FIX_LAST = FIX_W'(FIX_WRITES - 1);

    state_t state, state_next;

    logic             prg_prev;
    logic             dl_rise, dl_fall;
    logic [15:0]      pointer;
    logic [FIX_W-1:0] fix_idx;

    logic [23:0] fifo_mem [2];
    logic        wr_sel, rd_sel;
    logic [1:0]  fifo_count, count_next;

    logic hdr_wr, data_wr, fifo_pop, fix_issue;
    logic fifo_full, ptr_ok, fifo_push, ptr_inc, byte_drop;

    assign dl_rise   = prg_download & ~prg_prev;
    assign dl_fall   = ~prg_download & prg_prev;
    assign fifo_full = (fifo_count == 2'd2);
    assign ptr_ok    = (pointer < RAM_TOP);
    assign fifo_push = data_wr & ptr_ok & ~fifo_full;
    // A byte arriving while full still advances the pointer so later bytes land at the right address.
    assign ptr_inc   = data_wr & ptr_ok;
    assign byte_drop = data_wr & ~(ptr_ok & ~fifo_full);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (dl_rise) begin
            state_next = HDR;
        end else begin
            case (state)
                IDLE:  ;
                HDR:   if (dl_fall)                        state_next = FIN;
                       else if (hdr_wr && ioctl_addr[0])   state_next = DATA;
                DATA:  if (dl_fall)                        state_next = DRAIN;
                DRAIN: if (fifo_count == 2'd0 && !dma_we)  state_next = FIXUP;
                FIXUP: if (fix_issue && fix_idx == FIX_LAST) state_next = FIN;
                FIN:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        busy      = 1'b0;
        done      = 1'b0;
        hdr_wr    = 1'b0;
        data_wr   = 1'b0;
        fifo_pop  = 1'b0;
        fix_issue = 1'b0;
        case (state)
            HDR: begin
                busy   = 1'b1;
                hdr_wr = ioctl_wr && (ioctl_addr < 25'd2);
            end
            DATA: begin
                busy     = 1'b1;
                data_wr  = ioctl_wr && (ioctl_addr >= 25'd2);
                fifo_pop = dma_slot && (fifo_count != 2'd0);
            end
            DRAIN: begin
                busy     = 1'b1;
                fifo_pop = dma_slot && (fifo_count != 2'd0);
            end
            FIXUP: begin
                busy      = 1'b1;
                fix_issue = dma_slot;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
        // A restart abandons whatever was still queued.
        if (dl_rise) begin
            fifo_pop  = 1'b0;
            fix_issue = 1'b0;
        end
    end

    always_comb begin
        count_next = fifo_count;
        if (dl_rise)                     count_next = 2'd0;
        else if (fifo_push && !fifo_pop) count_next = fifo_count + 2'd1;
        else if (fifo_pop && !fifo_push) count_next = fifo_count - 2'd1;
    end

    // NOTE: FIFO storage has no reset; the count and select bits alone define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_sel] <= {pointer, ioctl_dout};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            prg_prev   <= 1'b0;
            ioctl_wait <= 1'b0;
            fifo_count <= 2'd0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            pointer    <= 16'h0000;
            fix_idx    <= '0;
            overflow   <= 1'b0;
            load_start <= 16'h0000;
            load_end   <= 16'h0000;
            dma_addr   <= 16'h0000;
            dma_din    <= 8'h00;
            dma_we     <= 1'b0;
        end else begin
            prg_prev   <= prg_download;
            ioctl_wait <= (count_next == 2'd2);
            fifo_count <= count_next;
            dma_we     <= 1'b0;
            if (dl_rise) begin
                wr_sel     <= 1'b0;
                rd_sel     <= 1'b0;
                pointer    <= 16'h0000;
                fix_idx    <= '0;
                overflow   <= 1'b0;
                load_start <= 16'h0000;
                load_end   <= 16'h0000;
            end else begin
                if (hdr_wr) begin
                    if (ioctl_addr[0]) begin
                        load_start[15:8] <= ioctl_dout;
                        pointer          <= {ioctl_dout, load_start[7:0]};
                    end else begin
                        load_start[7:0]  <= ioctl_dout;
                    end
                end
                if (fifo_push) wr_sel   <= ~wr_sel;
                if (ptr_inc)   pointer  <= pointer + 16'd1;
                if (byte_drop) overflow <= 1'b1;
                if (fifo_pop) begin
                    {dma_addr, dma_din} <= fifo_mem[rd_sel];
                    dma_we              <= 1'b1;
                    rd_sel              <= ~rd_sel;
                end
                if (state == DRAIN && state_next == FIXUP) load_end <= pointer;
                // Even fixup slots take the low byte, odd slots the high byte.
                if (fix_issue) begin
                    dma_addr <= FIXUP_BASE + 16'(fix_idx);
                    dma_din  <= fix_idx[0] ? pointer[15:8] : pointer[7:0];
                    dma_we   <= 1'b1;
                    fix_idx  <= fix_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prg_dma_loader.sv
// Scoreboard bench for prg_dma_loader: a file-level model queues the expected RAM
// writes, and a negedge monitor pops and compares every dma_we it observes.
module tb_prg_dma_loader;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        dma_slot;
    logic        prg_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] load_start;
    logic [15:0] load_end;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;
    int slot_period = 7;
    bit wait_seen = 1'b0;

    wr_t        exp_q[$];
    logic [7:0] file_q[$];
    logic [15:0] m_start, m_end;
    logic        m_ovf;

    prg_dma_loader dut (
        .clk          (clk),
        .reset        (reset),
        .dma_slot     (dma_slot),
        .prg_download (prg_download),
        .ioctl_wr     (ioctl_wr),
        .ioctl_addr   (ioctl_addr),
        .ioctl_dout   (ioctl_dout),
        .ioctl_wait   (ioctl_wait),
        .dma_addr     (dma_addr),
        .dma_din      (dma_din),
        .dma_we       (dma_we),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .load_start   (load_start),
        .load_end     (load_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // dma_slot strobe generator, one pulse every slot_period cycles
    initial begin
        int cnt = 0;
        dma_slot = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt >= slot_period) cnt = 0;
            dma_slot = (cnt == 0);
        end
    end

    // Monitor: every observed RAM write must be the next expected one
    initial begin
        forever begin
            @(negedge clk);
            if (ioctl_wait === 1'b1) wait_seen = 1'b1;
            if (dma_we === 1'b1) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_dma_we: got write %h=%h, required none", dma_addr, dma_din);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("dma_addr", {16'h0, dma_addr}, {16'h0, e.addr});
                    check("dma_din", {24'h0, dma_din}, {24'h0, e.data});
                end
            end
        end
    end

    // File-level reference: header, running pointer clipped at RAM top, pointer patch
    task automatic build_model();
        int ptr;
        wr_t w;
        m_start = 16'h0000;
        m_end   = 16'h0000;
        m_ovf   = 1'b0;
        if (file_q.size() >= 1) m_start[7:0]  = file_q[0];
        if (file_q.size() >= 2) m_start[15:8] = file_q[1];
        if (file_q.size() < 2) return;
        ptr = int'(m_start);
        for (int i = 2; i < file_q.size(); i++) begin
            if (ptr < 32'h8000) begin
                w.addr = 16'(ptr);
                w.data = file_q[i];
                exp_q.push_back(w);
                ptr++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_end = 16'(ptr);
        for (int j = 0; j < 6; j++) begin
            w.addr = 16'h002A + 16'(j);
            w.data = (j % 2 == 0) ? m_end[7:0] : m_end[15:8];
            exp_q.push_back(w);
        end
    endtask

    // Called at posedge+1 phase; returns at posedge+1 phase with prg_download low
    task automatic load_file(input int gap_max);
        build_model();
        prg_download = 1'b1;
        @(posedge clk); #1;
        check("ovf_clear_on_start", {31'h0, overflow}, 32'h0);
        check("busy_on_start", {31'h0, busy}, 32'h1);
        for (int i = 0; i < file_q.size(); i++) begin
            int guard = 0;
            while (ioctl_wait === 1'b1 && guard < 5000) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 5000) check("ioctl_wait_stuck", {31'h0, ioctl_wait}, 32'h0);
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = file_q[i];
            @(posedge clk); #1;
            ioctl_wr = 1'b0;
            for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
                @(posedge clk); #1;
            end
        end
        prg_download = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {31'h0, seen}, 32'h1);
        if (seen) begin
            check("busy_at_done", {31'h0, busy}, 32'h0);
            @(negedge clk);
            check("done_one_cycle", {31'h0, done}, 32'h0);
        end
        @(negedge clk);
        check("load_start", {16'h0, load_start}, {16'h0, m_start});
        check("load_end", {16'h0, load_end}, {16'h0, m_end});
        check("overflow", {31'h0, overflow}, {31'h0, m_ovf});
        check("pending_writes", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic set_file(input logic [15:0] start, input int ndata);
        file_q.delete();
        file_q.push_back(start[7:0]);
        file_q.push_back(start[15:8]);
        for (int i = 0; i < ndata; i++) file_q.push_back(8'($urandom));
    endtask

    initial begin
        int saved;
        int target;
        reset = 1'b1;
        prg_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_dma_we", {31'h0, dma_we}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_wait", {31'h0, ioctl_wait}, 32'h0);
        check("rst_ovf_ls_le", {overflow, load_start, load_end[14:0]}, 32'h0);
        @(posedge clk); #1;

        // Basic three-byte file
        slot_period = 7;
        file_q = '{8'h01, 8'h04, 8'h0A, 8'h0B, 8'h0C};
        load_file(1);
        wait_done();
        check("t1_load_end", {16'h0, load_end}, 32'h0404);

        // Back-to-back source against slow slots, throttled by ioctl_wait
        slot_period = 56;
        wait_seen = 1'b0;
        set_file(16'h1000, 20);
        load_file(0);
        wait_done();
        check("t2_wait_seen", {31'h0, wait_seen}, 32'h1);

        // Writes clipped at the top of RAM
        slot_period = 5;
        file_q = '{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33, 8'h44};
        load_file(2);
        wait_done();
        check("t3_overflow", {31'h0, overflow}, 32'h1);
        check("t3_load_end", {16'h0, load_end}, 32'h8000);

        // Header-only fragment: nothing written
        saved = wr_count;
        file_q = '{8'h33};
        load_file(0);
        wait_done();
        check("t4_no_writes", wr_count, saved);
        check("t4_load_end", {16'h0, load_end}, 32'h0);

        // Reset after two fixup writes
        slot_period = 7;
        set_file(16'h0200, 3);
        target = wr_count + 5;
        load_file(1);
        for (int k = 0; k < 5000 && wr_count < target; k++) begin
            @(posedge clk); #1;
        end
        check("t5_reached_fixup", wr_count, target);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("t5_dma_we", {31'h0, dma_we}, 32'h0);
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_outputs", {overflow, done, ioctl_wait, load_start, dma_din, 5'h0}, 32'h0);
        check("t5_addrs", {load_end, dma_addr}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        saved = wr_count;
        repeat (200) @(posedge clk);
        #1;
        check("t5_no_writes_after_reset", wr_count, saved);

        // Restart while draining an overflowed file
        slot_period = 56;
        set_file(16'h7FFA, 10);
        load_file(0);
        check("t6_ovf_before_restart", {31'h0, overflow}, 32'h1);
        saved = wr_count;
        for (int k = 0; k < 5000 && wr_count == saved; k++) begin
            @(posedge clk); #1;
        end
        check("t6_drain_write", wr_count, saved + 1);
        exp_q.delete();
        set_file(16'h0300, 4);
        load_file(0);
        wait_done();

        // Randomized files
        for (int t = 0; t < 6; t++) begin
            logic [15:0] st;
            st = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(32'h7FF0, 32'h8004))
                                              : 16'($urandom_range(32'h0400, 32'h7000));
            slot_period = $urandom_range(1, 9);
            set_file(st, $urandom_range(0, 12));
            load_file($urandom_range(0, 3));
            wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
